// File: rtl/output_arbiter_if.sv
// Handshake bundle between the input queues, the output arbiter and the downstream link.
// master = arbiter side, slave = queue/link side.
interface output_arbiter_if #(
  parameter int BUS_SIZE = 32,
  parameter int PORTS    = 4
);
  logic [PORTS-1:0]          empty_i;
  logic [PORTS*BUS_SIZE-1:0] data_i;
  logic [PORTS-1:0]          readed_o;
  logic                      ready_i;
  logic                      valid_o;
  logic [BUS_SIZE-1:0]       data_o;

  modport master (
    input  empty_i, data_i, ready_i,
    output readed_o, valid_o, data_o
  );

  modport slave (
    output empty_i, data_i, ready_i,
    input  readed_o, valid_o, data_o
  );
endinterface

// File: rtl/output_arbiter.sv
// Packet-granular round-robin arbiter: locks a grant to one queue until its tail flit is loaded.
// Optional macro ARB_STATS_EN adds flit_cnt_o, a wrapping count of forwarded flits.
module output_arbiter #(
  parameter int BUS_SIZE = 32,
  parameter int PORTS    = 4
) (
  input  logic               clk,
  input  logic               a_rst,
  output_arbiter_if.master   bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]        flit_cnt_o
`endif
);

  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic                valid_q, valid_d;
  logic [BUS_SIZE-1:0] data_q, data_d;

  logic [BUS_SIZE-1:0] head;
  logic                load_slot;
  logic                load;
  logic                found;
  logic [GW-1:0]       pick;
  logic [PORTS-1:0]    readed;

  assign head = bus.data_i[int'(grant_q)*BUS_SIZE +: BUS_SIZE];

  // Round-robin search starting just after the last served port.
  always_comb begin
    int            idx;
    logic [GW-1:0] idx_g;
    found = 1'b0;
    pick  = last_q;
    idx   = 0;
    idx_g = '0;
    for (int i = 1; i <= PORTS; i++) begin
      idx = int'(last_q) + i;
      if (idx >= PORTS) idx = idx - PORTS;
      idx_g = GW'(idx);
      if (!found && !bus.empty_i[idx_g]) begin
        found = 1'b1;
        pick  = idx_g;
      end
    end
  end

  always_comb begin
    load_slot = !valid_q || bus.ready_i;
    load      = (state_q == SEND) && load_slot && !bus.empty_i[grant_q];

    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    valid_d = valid_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = SEND;
        end
      end
      SEND: begin
        if (load && head[BUS_SIZE-1]) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled output (valid && !ready) leaves the register untouched.
    if (load) begin
      data_d  = head;
      valid_d = 1'b1;
    end else if (bus.ready_i) begin
      valid_d = 1'b0;
    end
  end

  // The pop pulse is suppressed during reset so the queue keeps the flit that reset discards.
  always_comb begin
    readed = '0;
    if (load && !a_rst) readed[grant_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (a_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(PORTS - 1);
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.readed_o = readed;
  assign bus.valid_o  = valid_q;
  assign bus.data_o   = data_q;

`ifdef ARB_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + 16'(|readed);

  always_ff @(posedge clk) begin
    if (a_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign flit_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Scoreboard bench for output_arbiter: queue models feed the DUT, expected flits are
// queued when stimulus is pushed and compared as the link accepts them.
module tb_output_arbiter;
  localparam int BUS = 32;
  localparam int P   = 4;

  logic clk = 1'b0;
  logic a_rst;
  always #5 clk = ~clk;

  output_arbiter_if #(.BUS_SIZE(BUS), .PORTS(P)) bus ();
`ifdef ARB_STATS_EN
  logic [15:0] flit_cnt;
`endif

  output_arbiter #(.BUS_SIZE(BUS), .PORTS(P)) dut (
    .clk   (clk),
    .a_rst (a_rst),
    .bus   (bus)
`ifdef ARB_STATS_EN
    ,
    .flit_cnt_o (flit_cnt)
`endif
  );

  logic [BUS-1:0] mq [P][$];
  logic [BUS-1:0] exp_q [$];
  logic [P-1:0]   rd_s;
  int total = 0;
  int bad   = 0;

  task automatic refresh();
    for (int k = 0; k < P; k++) begin
      bus.empty_i[k] = (mq[k].size() == 0);
      bus.data_i[k*BUS +: BUS] = (mq[k].size() != 0) ? mq[k][0] : '0;
    end
  endtask

  // Queue side: pops happen just after the edge that consumed the head flit.
  task automatic env_loop();
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < P; k++)
        if (rd_s[k] && mq[k].size() != 0) void'(mq[k].pop_front());
      rd_s = '0;
      refresh();
      @(negedge clk);
      #1;
      refresh();
    end
  endtask

  task automatic monitor_loop();
    logic [BUS-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (a_rst) begin
        rd_s = '0;
      end else begin
        rd_s = bus.readed_o;
        if (bus.readed_o != '0) begin
          total++;
          if ($countones(bus.readed_o) != 1 || (bus.readed_o & bus.empty_i) != '0) begin
            bad++;
            $display("FAIL readed_legal got=%b empty=%b required=onehot_to_nonempty", bus.readed_o, bus.empty_i);
          end
        end
        if (bus.valid_o && bus.ready_i) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_flit got=%h required=none", bus.data_o);
          end else begin
            e = exp_q.pop_front();
            if (bus.data_o !== e) begin
              bad++;
              $display("FAIL flit_order got=%h required=%h", bus.data_o, e);
            end
          end
        end
      end
    end
  endtask

  task automatic push(input int k, input logic [BUS-1:0] f);
    mq[k].push_back(f);
    exp_q.push_back(f);
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    exp_q.delete();
  endtask

  function automatic bit busy();
    bit b;
    b = (exp_q.size() != 0) || bus.valid_o;
    for (int k = 0; k < P; k++) if (mq[k].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #4;
      n++;
    end while (busy() && n < budget);
    total++;
    if (busy()) begin
      bad++;
      $display("FAIL %s_drain got=%0d_pending required=0 after %0d cycles", name, exp_q.size(), n);
    end
  endtask

  task automatic wait_readed(input string name, input logic [P-1:0] want);
    int n = 0;
    do begin
      @(negedge clk);
      #4;
      n++;
    end while (bus.readed_o !== want && n < 20);
    total++;
    if (bus.readed_o !== want) begin
      bad++;
      $display("FAIL %s_wait got=%b required=%b", name, bus.readed_o, want);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < P; k++) mq[k].delete();
    exp_q.delete();
    a_rst = 1'b1;
    bus.ready_i = 1'b1;
    refresh();
    repeat (3) @(negedge clk);
    #4;
    total += 3;
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b required=0", bus.valid_o); end
    if (bus.data_o !== '0) begin bad++; $display("FAIL rst_data got=%h required=0", bus.data_o); end
    if (bus.readed_o !== '0) begin bad++; $display("FAIL rst_readed got=%b required=0", bus.readed_o); end
`ifdef ARB_STATS_EN
    total++;
    if (flit_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d required=0", flit_cnt); end
`endif
    @(negedge clk);
    a_rst = 1'b0;
  endtask

  task automatic test_latency();
    @(negedge clk);
    push(2, 32'h8000_00AA);
    #4;
    total++;
    if (bus.readed_o !== 4'b0000 || bus.valid_o !== 1'b0) begin
      bad++; $display("FAIL lat_c1 got=%b/%b required=0000/0", bus.readed_o, bus.valid_o);
    end
    @(negedge clk);
    #4;
    total++;
    if (bus.readed_o !== 4'b0100) begin bad++; $display("FAIL lat_c2 got=%b required=0100", bus.readed_o); end
    @(negedge clk);
    #4;
    total++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== 32'h8000_00AA) begin
      bad++; $display("FAIL lat_c3 got=%b/%h required=1/800000aa", bus.valid_o, bus.data_o);
    end
    wait_drain("latency", 20);
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    push(1, 32'h8000_0101);
    wait_drain("rr_prime", 20);
    @(negedge clk);
    mq[1].push_back(32'h8000_0111);
    mq[3].push_back(32'h8000_0311);
    exp_q.push_back(32'h8000_0311);
    exp_q.push_back(32'h8000_0111);
    wait_drain("rr_pair", 30);
    do_reset();
    push(0, 32'h8000_0020);
    push(1, 32'h8000_0120);
    push(2, 32'h8000_0220);
    push(3, 32'h8000_0320);
    push(0, 32'h8000_0021);
    wait_drain("rr_all", 40);
  endtask

  task automatic test_multi_flit();
    do_reset();
    @(negedge clk);
    push(0, 32'h0000_0001);
    push(0, 32'h0000_0002);
    push(0, 32'h8000_0003);
    push(1, 32'h8000_0101);
    wait_readed("multi_first", 4'b0001);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #4;
      total++;
      if (bus.readed_o !== 4'b0001) begin bad++; $display("FAIL multi_pulse%0d got=%b required=0001", i, bus.readed_o); end
    end
    @(negedge clk);
    #4;
    total++;
    if (bus.readed_o !== 4'b0000) begin bad++; $display("FAIL multi_gap got=%b required=0000", bus.readed_o); end
    @(negedge clk);
    #4;
    total++;
    if (bus.readed_o !== 4'b0010) begin bad++; $display("FAIL multi_next got=%b required=0010", bus.readed_o); end
    wait_drain("multi", 30);
  endtask

  task automatic test_stall();
    logic [BUS-1:0] hold;
    int n = 0;
    @(negedge clk);
    push(2, 32'h0000_0A01);
    push(2, 32'h0000_0A02);
    push(2, 32'h0000_0A03);
    push(2, 32'h8000_0A04);
    do begin @(negedge clk); #4; n++; end while (!bus.valid_o && n < 20);
    @(negedge clk);
    bus.ready_i = 1'b0;
    #4;
    hold = bus.data_o;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin @(negedge clk); #4; end
      total++;
      if (bus.data_o !== hold || bus.valid_o !== 1'b1 || bus.readed_o !== '0) begin
        bad++; $display("FAIL stall_c%0d got=%h/%b/%b required=%h/1/0000", i, bus.data_o, bus.valid_o, bus.readed_o, hold);
      end
    end
    @(negedge clk);
    bus.ready_i = 1'b1;
    #4;
    total++;
    if (bus.readed_o !== 4'b0100) begin bad++; $display("FAIL stall_resume got=%b required=0100", bus.readed_o); end
    wait_drain("stall", 30);
  endtask

  task automatic test_empty_mid();
    do_reset();
    @(negedge clk);
    mq[0].push_back(32'h0000_0001);
    mq[1].push_back(32'h8000_0101);
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h0000_0002);
    exp_q.push_back(32'h8000_0003);
    exp_q.push_back(32'h8000_0101);
    wait_readed("emid_first", 4'b0001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #4;
      total++;
      if (bus.readed_o !== '0) begin bad++; $display("FAIL emid_hold%0d got=%b required=0000", i, bus.readed_o); end
    end
    @(negedge clk);
    mq[0].push_back(32'h0000_0002);
    mq[0].push_back(32'h8000_0003);
    wait_drain("emid", 30);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    push(3, 32'h0000_0031);
    push(3, 32'h0000_0032);
    push(3, 32'h8000_0033);
    wait_readed("rmid_first", 4'b1000);
    @(negedge clk);
    a_rst = 1'b1;
    #4;
    total++;
    if (bus.readed_o !== '0) begin bad++; $display("FAIL rmid_readed got=%b required=0000", bus.readed_o); end
    @(negedge clk);
    a_rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0000_0032);
    exp_q.push_back(32'h8000_0033);
    #4;
    total++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== '0) begin
      bad++; $display("FAIL rmid_out got=%b/%h required=0/0", bus.valid_o, bus.data_o);
    end
`ifdef ARB_STATS_EN
    total++;
    if (flit_cnt !== 16'd0) begin bad++; $display("FAIL rmid_cnt got=%0d required=0", flit_cnt); end
`endif
    wait_drain("rmid", 30);
  endtask

`ifdef ARB_STATS_EN
  task automatic test_cnt_wrap();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 65535; i++) push(0, BUS'(i));
    push(0, 32'h8000_FFFF);
    wait_drain("wrap", 70000);
    total++;
    if (flit_cnt !== 16'd0) begin bad++; $display("FAIL cnt_wrap got=%0d required=0", flit_cnt); end
  endtask
`endif

  initial begin
    rd_s = '0;
    a_rst = 1'b1;
    bus.ready_i = 1'b1;
    refresh();
    fork
      env_loop();
      monitor_loop();
    join_none
    test_reset();
    test_latency();
    test_round_robin();
    test_multi_flit();
    test_stall();
    test_empty_mid();
    test_reset_mid();
`ifdef ARB_STATS_EN
    test_cnt_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
